// File: rtl/aud_codec_config.sv
// aud_codec_config
//   Power-up register sequencer for a WM8731-class audio codec. Walks a fixed
//   11-entry table and writes each {reg[6:0], data[8:0]} word to the codec over
//   a built-in I2C write-only master. The result is a 16-bit I2S slave at 48 kHz
//   with DAC -> headphone routing. Audio logic downstream waits for oDone.
//
//   Ports:
//     iCLK, iRST_N   system clock, async active-low reset
//     iStart         re-run the table (honoured only in IDLE/DONE/ERR, on a tick)
//     oI2C_SCLK      I2C clock, push-pull
//     ioI2C_SDAT     I2C data, open-drain (drives 0 or Z only)
//     oBusy          a frame or inter-frame gap is in progress
//     oDone / oErr   run completed with all ACKs / run aborted on NACK
//     oIndex         table entry being sent, or last entry attempted
//
//   Build option: define AUD_CFG_RETRY_EN to resend a NACKed entry up to three
//   times before giving up; without it the first NACK ends the run.
module aud_codec_config #(
  parameter int          CLK_FREQ = 50000000,
  parameter int          I2C_FREQ = 20000,
  parameter logic [7:0]  DEV_ADDR = 8'h34,
  parameter int          LUT_SIZE = 11
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iStart,
  output logic       oI2C_SCLK,
  inout  wire        ioI2C_SDAT,
  output logic       oBusy,
  output logic       oDone,
  output logic       oErr,
  output logic [3:0] oIndex
);

  localparam int QTR   = CLK_FREQ / (I2C_FREQ * 4);
  localparam int DIV_W = (QTR > 1) ? $clog2(QTR) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(QTR - 1);
  localparam logic [3:0]       IDX_LAST = 4'(LUT_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_GAP, S_DONE, S_ERR
  } state_e;

  // Codec register table, in write order.
  function automatic logic [15:0] lut_word(input logic [3:0] i);
    case (i)
      4'd0:    lut_word = {7'd15, 9'h000};  // reset
      4'd1:    lut_word = {7'd0,  9'h017};  // left line in
      4'd2:    lut_word = {7'd1,  9'h017};  // right line in
      4'd3:    lut_word = {7'd2,  9'h079};  // left headphone
      4'd4:    lut_word = {7'd3,  9'h079};  // right headphone
      4'd5:    lut_word = {7'd4,  9'h012};  // analog path: DAC select
      4'd6:    lut_word = {7'd5,  9'h000};  // digital path
      4'd7:    lut_word = {7'd6,  9'h000};  // power down control
      4'd8:    lut_word = {7'd7,  9'h002};  // I2S, 16-bit, slave
      4'd9:    lut_word = {7'd8,  9'h000};  // sampling: 48 kHz
      4'd10:   lut_word = {7'd9,  9'h001};  // activate
      default: lut_word = 16'h0000;
    endcase
  endfunction

  // Quarter-period tick, free-running from reset.
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;

  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + 1'b1;
  end

  state_e     state_q, state_d;
  logic [1:0] qtr_q, qtr_d;     // quarter within the current state
  logic [2:0] bit_q, bit_d;     // bit within byte, MSB first
  logic [1:0] byte_q, byte_d;   // 0 = device address, 1 = word hi, 2 = word lo
  logic [3:0] idx_q, idx_d;
  logic       nack_q, nack_d;
  logic       scl_q, scl_d;
  logic       sda_oe_q, sda_oe_d;  // 1 pulls SDA low
`ifdef AUD_CFG_RETRY_EN
  logic [1:0] retry_q, retry_d;
`endif

  logic [15:0] word;
  logic [7:0]  cur_byte;
  logic        cur_bit;

  always_comb begin
    word = lut_word(idx_q);
    case (byte_q)
      2'd0:    cur_byte = DEV_ADDR;
      2'd1:    cur_byte = word[15:8];
      default: cur_byte = word[7:0];
    endcase
    cur_bit = cur_byte[bit_q];
  end

  // State register
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      div_q    <= '0;
      state_q  <= S_IDLE;
      qtr_q    <= 2'd0;
      bit_q    <= 3'd7;
      byte_q   <= 2'd0;
      idx_q    <= 4'd0;
      nack_q   <= 1'b0;
      scl_q    <= 1'b1;
      sda_oe_q <= 1'b0;
`ifdef AUD_CFG_RETRY_EN
      retry_q  <= 2'd0;
`endif
    end else begin
      div_q    <= div_d;
      state_q  <= state_d;
      qtr_q    <= qtr_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      idx_q    <= idx_d;
      nack_q   <= nack_d;
      scl_q    <= scl_d;
      sda_oe_q <= sda_oe_d;
`ifdef AUD_CFG_RETRY_EN
      retry_q  <= retry_d;
`endif
    end
  end

  // Next-state logic; everything advances on the quarter tick only.
  always_comb begin
    state_d = state_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    idx_d   = idx_q;
    nack_d  = nack_q;
`ifdef AUD_CFG_RETRY_EN
    retry_d = retry_q;
`endif
    if (tick) begin
      qtr_d = qtr_q + 2'd1;  // 3 -> 0 wrap lines up with the state change
      case (state_q)
        S_IDLE: begin
          state_d = S_START;
          qtr_d   = 2'd0;
          idx_d   = 4'd0;
        end
        S_DONE, S_ERR: begin
          qtr_d = 2'd0;
          if (iStart) begin
            state_d = S_START;
            idx_d   = 4'd0;
`ifdef AUD_CFG_RETRY_EN
            retry_d = 2'd0;
`endif
          end
        end
        S_START: if (qtr_q == 2'd3) begin
          state_d = S_BIT;
          bit_d   = 3'd7;
          byte_d  = 2'd0;
          nack_d  = 1'b0;
        end
        S_BIT: if (qtr_q == 2'd3) begin
          if (bit_q == 3'd0) state_d = S_ACK;
          else               bit_d   = bit_q - 3'd1;
        end
        S_ACK: begin
          if (qtr_q == 2'd2) nack_d = ioI2C_SDAT;  // released line reads 1 = NACK
          if (qtr_q == 2'd3) begin
            if (nack_q || byte_q == 2'd2) begin
              state_d = S_STOP;
            end else begin
              state_d = S_BIT;
              bit_d   = 3'd7;
              byte_d  = byte_q + 2'd1;
            end
          end
        end
        S_STOP: if (qtr_q == 2'd3) begin
`ifdef AUD_CFG_RETRY_EN
          state_d = (nack_q && retry_q == 2'd3) ? S_ERR : S_GAP;
`else
          state_d = nack_q ? S_ERR : S_GAP;
`endif
        end
        S_GAP: if (qtr_q == 2'd3) begin
`ifdef AUD_CFG_RETRY_EN
          if (nack_q) begin
            // resend the same entry
            retry_d = retry_q + 2'd1;
            state_d = S_START;
          end else begin
            retry_d = 2'd0;
            if (idx_q == IDX_LAST) state_d = S_DONE;
            else begin
              idx_d   = idx_q + 4'd1;
              state_d = S_START;
            end
          end
`else
          if (idx_q == IDX_LAST) state_d = S_DONE;
          else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_START;
          end
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Bus outputs decoded from state/quarter, then registered so the pins
  // never glitch while several state bits change together.
  always_comb begin
    scl_d    = 1'b1;
    sda_oe_d = 1'b0;
    case (state_q)
      S_START: begin
        sda_oe_d = (qtr_q != 2'd0);   // SDA falls with SCL high
        scl_d    = (qtr_q != 2'd3);   // then SCL falls
      end
      S_BIT: begin
        sda_oe_d = ~cur_bit;
        scl_d    = (qtr_q == 2'd1) || (qtr_q == 2'd2);
      end
      S_ACK: begin
        sda_oe_d = 1'b0;
        scl_d    = (qtr_q == 2'd1) || (qtr_q == 2'd2);
      end
      S_STOP: begin
        sda_oe_d = (qtr_q < 2'd2);    // release SDA while SCL high
        scl_d    = (qtr_q != 2'd0);
      end
      default: ;
    endcase
  end

  assign oI2C_SCLK  = scl_q;
  assign ioI2C_SDAT = sda_oe_q ? 1'b0 : 1'bz;
  assign oBusy      = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
  assign oDone      = (state_q == S_DONE);
  assign oErr       = (state_q == S_ERR);
  assign oIndex     = idx_q;

endmodule

// File: tb/tb_aud_codec_config.sv
module tb_aud_codec_config;
  localparam int CLK_FREQ = 80;
  localparam int I2C_FREQ = 5;
  localparam int QTR      = 4;   // CLK_FREQ / (I2C_FREQ*4)
  localparam int CLK_P    = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       scl;
  wire        sda;
  logic       busy, done, err;
  logic [3:0] idx;
  logic       slv_drv = 1'b0;

  assign sda = slv_drv ? 1'b0 : 1'bz;
  pullup (sda);

  always #(CLK_P/2) clk = ~clk;

  aud_codec_config #(
    .CLK_FREQ(CLK_FREQ), .I2C_FREQ(I2C_FREQ), .DEV_ADDR(8'h34), .LUT_SIZE(11)
  ) dut (
    .iCLK(clk), .iRST_N(rst_n), .iStart(start),
    .oI2C_SCLK(scl), .ioI2C_SDAT(sda),
    .oBusy(busy), .oDone(done), .oErr(err), .oIndex(idx)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Expected table, written from the codec register map.
  logic [6:0] exp_reg [0:10] = '{7'd15, 7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6, 7'd7, 7'd8, 7'd9};
  logic [8:0] exp_dat [0:10] = '{9'h000, 9'h017, 9'h017, 9'h079, 9'h079, 9'h012,
                                 9'h000, 9'h000, 9'h002, 9'h000, 9'h001};
  logic [23:0] exp_q [$];

  task automatic push_entry(input int e);
    exp_q.push_back({8'h34, exp_reg[e], exp_dat[e]});
  endtask

  // ---------------- bus monitor + codec ACK model ----------------
  logic        in_frame = 1'b0;
  int          nbits = 0;
  logic [27:0] sh = '0;
  int          frames = 0;
  time         t_fall = 0, t_rise = 0;
  logic        sda_chg_hi = 1'b0;
  logic [7:0]  nack_hi = 8'h00;   // word hi byte of the entry to NACK
  int          nack_left = 0;     // how many of its attempts to NACK

  always @(negedge rst_n) begin
    in_frame = 1'b0;
    nbits    = 0;
    slv_drv  = 1'b0;
  end

  // START: SDA falls while SCL high
  always @(negedge sda) begin
    if (rst_n && scl) begin
      chk("start_outside_frame", in_frame, 1'b0);
      in_frame   = 1'b1;
      nbits      = 0;
      sda_chg_hi = 1'b1;
    end
  end

  // STOP: SDA rises while SCL high; frame goes to the scoreboard
  always @(posedge sda) begin
    if (rst_n && scl) begin
      sda_chg_hi = 1'b1;
      chk("stop_inside_frame", in_frame, 1'b1);
      if (in_frame) begin
        logic [23:0] e;
        in_frame = 1'b0;
        frames++;
        chk("frame_bits", nbits, 28);  // 27 bits + the STOP rising edge
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", {sh[27:20], sh[18:11], sh[9:2]}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("frame_bytes", {sh[27:20], sh[18:11], sh[9:2]}, e);
        end
      end
    end
  end

  always @(posedge scl) begin
    if (rst_n && in_frame) begin
      chk("scl_low_phase", 32'(($time - t_fall) / CLK_P), 2*QTR);
      sh = {sh[26:0], sda};
      nbits++;
    end
    t_rise     = $time;
    sda_chg_hi = 1'b0;
  end

  always @(negedge scl) begin
    if (rst_n && in_frame) begin
      if (!sda_chg_hi)
        chk("scl_high_phase", 32'(($time - t_rise) / CLK_P), 2*QTR);
      if (nbits == 8 || nbits == 17) begin
        slv_drv = 1'b1;
      end else if (nbits == 26) begin
        if (nack_left > 0 && sh[16:9] == nack_hi) begin
          nack_left--;
          slv_drv = 1'b0;
        end else begin
          slv_drv = 1'b1;
        end
      end else begin
        slv_drv = 1'b0;
      end
    end
    t_fall = $time;
  end

  // ---------------- stimulus ----------------
  task automatic wait_end(input int max_cyc, output int n);
    n = 0;
    while (!(done || err) && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic kick();
    int n;
    @(negedge clk); start = 1'b1;
    n = 0;
    while (!busy && n < QTR + 2) begin
      @(posedge clk); #1;
      n++;
    end
    chk("kick_busy", busy, 1'b1);
    chk("kick_done_clr", done, 1'b0);
    chk("kick_err_clr", err, 1'b0);
    chk("kick_idx0", idx, 4'd0);
    @(negedge clk); start = 1'b0;
  endtask

  initial begin
    int n, f0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_scl", scl, 1'b1);
    chk("rst_sda", sda, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_idx", idx, 4'd0);

    // 1: run from reset release
    for (int e = 0; e < 11; e++) push_entry(e);
    @(negedge clk); rst_n = 1'b1;
    wait_end(7000, n);
    chk("run1_len_ok", (n >= 5280 && n <= 5288), 1'b1);
    chk("run1_done", done, 1'b1);
    chk("run1_busy", busy, 1'b0);
    chk("run1_err", err, 1'b0);
    chk("run1_idx", idx, 4'd10);
    chk("run1_q_empty", exp_q.size(), 0);

    // 2: restart after DONE, iStart during entry 5 is ignored
    f0 = frames;
    for (int e = 0; e < 11; e++) push_entry(e);
    kick();
    n = 0;
    while (idx != 4'd5 && n < 4000) begin @(posedge clk); #1; n++; end
    chk("run2_reach_idx5", idx, 4'd5);
    @(negedge clk); start = 1'b1;
    repeat (3*QTR) @(negedge clk);
    start = 1'b0;
    wait_end(7000, n);
    chk("run2_done", done, 1'b1);
    chk("run2_err", err, 1'b0);
    chk("run2_frames", frames - f0, 11);
    chk("run2_q_empty", exp_q.size(), 0);

    // 3: NACK second data byte of entry 3 (R2 -> hi byte 8'h04), first attempt only
    f0 = frames;
    nack_hi = 8'h04; nack_left = 1;
`ifdef AUD_CFG_RETRY_EN
    for (int e = 0; e < 4; e++) push_entry(e);
    for (int e = 3; e < 11; e++) push_entry(e);
    kick();
    wait_end(7000, n);
    chk("nack_done", done, 1'b1);
    chk("nack_err", err, 1'b0);
    chk("nack_frames", frames - f0, 12);
`else
    for (int e = 0; e < 4; e++) push_entry(e);
    kick();
    wait_end(7000, n);
    chk("nack_err", err, 1'b1);
    chk("nack_done", done, 1'b0);
    chk("nack_idx", idx, 4'd3);
    repeat (400) @(posedge clk);
    #1;
    chk("nack_frames", frames - f0, 4);
    chk("nack_idle_scl", scl, 1'b1);
`endif
    chk("nack_q_empty", exp_q.size(), 0);

    // 4: persistent NACK on entry 0 (R15 -> hi byte 8'h1E)
    f0 = frames;
    nack_hi = 8'h1E; nack_left = 4;
`ifdef AUD_CFG_RETRY_EN
    for (int r = 0; r < 4; r++) push_entry(0);
`else
    push_entry(0);
`endif
    kick();
    wait_end(7000, n);
    chk("hardnack_err", err, 1'b1);
    chk("hardnack_done", done, 1'b0);
    chk("hardnack_idx", idx, 4'd0);
`ifdef AUD_CFG_RETRY_EN
    chk("hardnack_frames", frames - f0, 4);
`else
    chk("hardnack_frames", frames - f0, 1);
`endif
    chk("hardnack_q_empty", exp_q.size(), 0);
    nack_left = 0;

    // 5: async reset during entry 6, bit 10
    for (int e = 0; e < 6; e++) push_entry(e);
    kick();
    n = 0;
    while (!(idx == 4'd6 && nbits == 10) && n < 5000) begin @(posedge clk); #1; n++; end
    chk("rstmid_reached", (idx == 4'd6 && nbits == 10), 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_scl", scl, 1'b1);
    chk("rstmid_sda", sda, 1'b1);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_done", done, 1'b0);
    chk("rstmid_err", err, 1'b0);
    chk("rstmid_idx", idx, 4'd0);
    chk("rstmid_q_empty", exp_q.size(), 0);
    f0 = frames;
    for (int e = 0; e < 11; e++) push_entry(e);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_end(7000, n);
    chk("rstrun_done", done, 1'b1);
    chk("rstrun_err", err, 1'b0);
    chk("rstrun_frames", frames - f0, 11);
    chk("rstrun_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #(80000 * CLK_P);
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aud_codec_config.md
# aud_codec_config

Register-configuration sequencer for the audio codec (WM8731-class) feeding the board's I2S DAC path. After reset, or on request, it walks a fixed 11-entry register table and writes each entry to the codec over a built-in I2C master. This sets the codec to a 16-bit I2S slave at 48 kHz with the DAC routed to the headphone output. It sits beside the audio serializer; downstream audio logic should hold off until `oDone` is set.

## Interface
- `CLK_FREQ`, 50000000: iCLK frequency in Hz.
- `I2C_FREQ`, 20000: SCLK frequency in Hz. Quarter-period tick = CLK_FREQ/(I2C_FREQ*4) cycles (625 at defaults).
- `DEV_ADDR`, 8'h34: codec write address byte (R/W bit = 0).
- `LUT_SIZE`, 11: number of table entries.
- `iCLK` in 1: system clock. One clock only.
- `iRST_N` in 1: reset, asynchronous, active-low.
- `iStart` in 1: level-sampled pulse that re-runs the whole table. Honoured only in IDLE, DONE or ERR.
- `oI2C_SCLK` out 1: I2C clock. Driven push-pull.
- `ioI2C_SDAT` inout 1: I2C data. Open-drain: drives 0 or Z, never 1. Sampled for ACK.
- `oBusy` out 1: high while any frame or gap is in progress.
- `oDone` out 1: high after every entry was ACKed. Cleared on a new run.
- `oErr` out 1: high if the run terminated on a NACK. Cleared on a new run.
- `oIndex` out 4: table entry currently being sent, or last entry attempted.

## Operation
- Table: 16-bit words {reg[6:0], data[8:0]}, in this order:
  - R15 = 9'h000 (reset)
  - R0 = 9'h017, R1 = 9'h017
  - R2 = 9'h079, R3 = 9'h079
  - R4 = 9'h012, R5 = 9'h000, R6 = 9'h000
  - R7 = 9'h002
  - R8 = 9'h000
  - R9 = 9'h001
- Frame per entry: START, DEV_ADDR, ACK, word[15:8], ACK, word[7:0], ACK, STOP. Bytes go MSB first.
- FSM states: IDLE → START → BIT → ACK → (BIT | STOP) → GAP → (START of next entry | DONE); on a NACK, ACK → STOP → ERR.
  - After reset the FSM leaves IDLE automatically on the first tick.
  - DONE and ERR return to START (index 0) on `iStart`.
- START: SDA falls while SCLK is high, then SCLK falls.
- Each data or ACK bit takes 4 quarters:
  - q0: set SDA, SCLK low.
  - q1: SCLK rises.
  - q2: in the ACK state, sample SDA. A value of 1 is a NACK.
  - q3: SCLK falls.
- During ACK, SDA is released (Z).
- STOP: SDA low, SCLK rises, then SDA is released while SCLK is high.
- GAP: 4 quarters of bus idle between frames.
- Index increments in GAP. Wrap: the entry at index LUT_SIZE-1 goes to DONE; it does not wrap to 0.
- The tick divider free-runs from reset. Every FSM action happens on a tick, so the reaction to `iStart` waits for the next tick.
- Reset mid-frame: SCLK goes to 1 and SDA to Z immediately, with no STOP issued. All outputs return to reset values, and the table restarts from index 0 on the first tick.
- `iStart` while busy: ignored, not queued.

## Timing
- Reset values:
  - oI2C_SCLK = 1, ioI2C_SDAT = Z
  - oBusy = 0, oDone = 0, oErr = 0, oIndex = 0
- Frame length: START 4 + 27 bits × 4 + STOP 4 = 116 quarters, plus GAP 4, giving 120 quarters per entry.
- Full run: 11 × 120 = 1320 quarters = 825000 iCLK cycles at defaults, plus up to one tick of start latency.
- oDone and oErr assert on the iCLK edge after the final GAP or STOP quarter completes. oBusy falls on the same edge.
- oBusy rises on the same edge on which the FSM leaves IDLE, DONE or ERR.
- SDA changes only while SCLK is low, except inside START and STOP.

## Configuration
- `AUD_CFG_RETRY_EN` defined: a NACK does not abort the run.
  - STOP and GAP are issued, then the same entry is resent.
  - Up to 3 retries per entry; the retry counter resets on every ACKed entry.
  - The 4th consecutive NACK on an entry goes to ERR.
- Macro undefined: the first NACK goes STOP → ERR, with oIndex holding the failing entry. No retry counter is built.

## Test plan
- Reset release, ACK model always 0 → 11 frames are observed, with frame 8 bytes = 8'h34, 8'h0E, 8'h02. oDone = 1 and oBusy = 0 at cycle ≈ 825000 (±625); oErr = 0.
- Model NACKs the second data byte of entry 3, retry macro undefined → STOP is seen, oErr = 1, oIndex = 3, oDone = 0, and no further START.
- Same NACK only on the first attempt, `AUD_CFG_RETRY_EN` defined → entry 3 is sent twice, the run completes with oDone = 1, oErr = 0, and 12 frames in total.
- `iStart` pulsed mid-run at entry 5 → ignored, with the run ending after 11 frames. `iStart` pulsed after DONE → oDone clears, oBusy = 1 on the next tick, and a new run starts at index 0.
- iRST_N asserted during entry 6, bit 10 → SCLK = 1, SDA = Z, and all outputs at reset values in the same cycle (asynchronous). After release, the first frame sent is entry 0.
- Protocol checker across all runs → SDA never driven to 1, SDA changes only while SCLK is low outside START/STOP, and SCLK high and low phases each equal 2 quarters (1250 cycles).
